// File: rtl/tmds_pkg.sv
// Shared constants and types for the TMDS 8b/10b channel encoder.
// Control tokens, the default disparity width and the 10-bit symbol type.
package tmds_pkg;

    localparam int TMDS_DISP_W_DEF = 6;

    typedef logic [9:0] tmds_sym_t;

    localparam tmds_sym_t TMDS_CTRL_00 = 10'h354;
    localparam tmds_sym_t TMDS_CTRL_01 = 10'h0AB;
    localparam tmds_sym_t TMDS_CTRL_10 = 10'h154;
    localparam tmds_sym_t TMDS_CTRL_11 = 10'h2AB;

    function automatic tmds_sym_t tmds_ctrl_token(input logic c1, input logic c0);
        tmds_sym_t tok;
        case ({c1, c0})
            2'b00:   tok = TMDS_CTRL_00;
            2'b01:   tok = TMDS_CTRL_01;
            2'b10:   tok = TMDS_CTRL_10;
            2'b11:   tok = TMDS_CTRL_11;
            default: tok = TMDS_CTRL_00;
        endcase
        return tok;
    endfunction

endpackage

// File: rtl/tmds_popcount.sv
// Combinational ones counter for an 8-bit word, 4-bit result (0..8).
module tmds_popcount (
    input  logic [7:0] i_data,
    output logic [3:0] o_count
);

    // Sum the set bits of the input word
    always_comb begin
        o_count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            o_count = o_count + {3'b000, i_data[i]};
        end
    end

endmodule

// File: rtl/tmds_encoder.sv
// DVI/HDMI TMDS 8b/10b channel encoder: transition minimisation then DC balance.
// Optional macro TMDS_DISP_MON_EN exposes the running disparity on port disp.
module tmds_encoder
    import tmds_pkg::*;
#(
    parameter int DISP_W = TMDS_DISP_W_DEF
) (
    input  logic                     clk1x,
    input  logic                     rst_n,
    input  logic                     de,
    input  logic                     c0,
    input  logic                     c1,
    input  logic [7:0]               din,
`ifdef TMDS_DISP_MON_EN
    output logic signed [DISP_W-1:0] disp,
`endif
    output logic [9:0]               dout
);

    logic [3:0]               w_n1;
    logic                     w_use_xnor;
    logic [8:0]               w_qm;
    logic [8:0]               r_qm;
    logic                     r_de;
    logic                     r_c0;
    logic                     r_c1;
    logic [3:0]               w_n1q;
    logic [3:0]               w_n0q;
    logic signed [DISP_W-1:0] w_n1q_x;
    logic signed [DISP_W-1:0] w_n0q_x;
    logic signed [DISP_W-1:0] w_diff;
    logic signed [DISP_W-1:0] w_two_qm8;
    logic signed [DISP_W-1:0] w_two_nqm8;
    logic                     w_cnt_zero;
    logic                     w_cnt_pos;
    logic                     w_cnt_neg;
    tmds_sym_t                w_dout_nxt;
    logic signed [DISP_W-1:0] w_cnt_nxt;
    tmds_sym_t                r_dout;
    logic signed [DISP_W-1:0] r_cnt;

    tmds_popcount u_pop_din (
        .i_data  (din),
        .o_count (w_n1)
    );

    assign w_use_xnor = (w_n1 > 4'd4) || ((w_n1 == 4'd4) && !din[0]);

    // Stage 1 chain: XOR mode, or XNOR mode by inverting each link
    always_comb begin
        w_qm    = 9'd0;
        w_qm[0] = din[0];
        for (int i = 1; i < 8; i++) begin
            w_qm[i] = w_qm[i-1] ^ din[i] ^ w_use_xnor;
        end
        w_qm[8] = !w_use_xnor;
    end

    // Stage 1 pipeline register; reset looks like a 00 control cycle
    always_ff @(posedge clk1x or negedge rst_n) begin
        if (!rst_n) begin
            r_qm <= 9'd0;
            r_de <= 1'b0;
            r_c0 <= 1'b0;
            r_c1 <= 1'b0;
        end else begin
            r_qm <= w_qm;
            r_de <= de;
            r_c0 <= c0;
            r_c1 <= c1;
        end
    end

    tmds_popcount u_pop_qm (
        .i_data  (r_qm[7:0]),
        .o_count (w_n1q)
    );

    assign w_n0q      = 4'd8 - w_n1q;
    assign w_n1q_x    = $signed({{(DISP_W-4){1'b0}}, w_n1q});
    assign w_n0q_x    = $signed({{(DISP_W-4){1'b0}}, w_n0q});
    assign w_diff     = w_n1q_x - w_n0q_x;
    assign w_two_qm8  = $signed({{(DISP_W-2){1'b0}}, r_qm[8], 1'b0});
    assign w_two_nqm8 = $signed({{(DISP_W-2){1'b0}}, !r_qm[8], 1'b0});
    assign w_cnt_zero = (r_cnt == {DISP_W{1'b0}});
    assign w_cnt_neg  = r_cnt[DISP_W-1];
    assign w_cnt_pos  = !w_cnt_neg && !w_cnt_zero;

    // Stage 2: pick symbol polarity that steers the running disparity toward zero
    always_comb begin
        w_dout_nxt = TMDS_CTRL_00;
        w_cnt_nxt  = r_cnt;
        if (!r_de) begin
            w_dout_nxt = tmds_ctrl_token(r_c1, r_c0);
            w_cnt_nxt  = {DISP_W{1'b0}};
        end else if (w_cnt_zero || (w_n1q == w_n0q)) begin
            w_dout_nxt = {!r_qm[8], r_qm[8], (r_qm[8] ? r_qm[7:0] : ~r_qm[7:0])};
            if (r_qm[8]) begin
                w_cnt_nxt = r_cnt + w_diff;
            end else begin
                w_cnt_nxt = r_cnt - w_diff;
            end
        end else if ((w_cnt_pos && (w_n1q > w_n0q)) || (w_cnt_neg && (w_n0q > w_n1q))) begin
            w_dout_nxt = {1'b1, r_qm[8], ~r_qm[7:0]};
            w_cnt_nxt  = r_cnt + w_two_qm8 - w_diff;
        end else begin
            w_dout_nxt = {1'b0, r_qm[8], r_qm[7:0]};
            w_cnt_nxt  = r_cnt - w_two_nqm8 + w_diff;
        end
    end

    // Stage 2 output and disparity registers
    always_ff @(posedge clk1x or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= TMDS_CTRL_00;
            r_cnt  <= {DISP_W{1'b0}};
        end else begin
            r_dout <= w_dout_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign dout = r_dout;
`ifdef TMDS_DISP_MON_EN
    assign disp = r_cnt;
`endif

endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder: directed hand-computed vectors plus a model-checked random run.
module tb_tmds_encoder;

    localparam int DISP_W = 6;

    logic        clk1x = 1'b0;
    logic        rst_n = 1'b0;
    logic        de    = 1'b0;
    logic        c0    = 1'b0;
    logic        c1    = 1'b0;
    logic [7:0]  din   = 8'd0;
    logic [9:0]  dout;
`ifdef TMDS_DISP_MON_EN
    logic signed [DISP_W-1:0] disp;
`endif

    tmds_encoder #(.DISP_W(DISP_W)) dut (
        .clk1x (clk1x),
        .rst_n (rst_n),
        .de    (de),
        .c0    (c0),
        .c1    (c1),
        .din   (din),
`ifdef TMDS_DISP_MON_EN
        .disp  (disp),
`endif
        .dout  (dout)
    );

    always #5 clk1x = ~clk1x;

    typedef struct {
        int         due;
        logic [9:0] sym;
        int         cnt;
        logic       is_data;
        logic [7:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cur_edge = 0;
    int   mdl_cnt = 0;

    always @(posedge clk1x) cur_edge <= cur_edge + 1;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
                     name, act, act, exp, exp, cur_edge);
        end
    endtask

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] qm;
        logic [7:0] d;
        qm   = s[9] ? ~s[7:0] : s[7:0];
        d[0] = qm[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (qm[i] ^ qm[i-1]) : ~(qm[i] ^ qm[i-1]);
        return d;
    endfunction

    // Reference encoder, integer arithmetic straight from the algorithm description
    task automatic model(input logic m_de, input logic m_c1, input logic m_c0, input logic [7:0] d,
                         inout int cnt, output logic [9:0] sym);
        int n1, n1q, n0q, qm8;
        logic [7:0] qm;
        logic use_xnor;
        if (!m_de) begin
            case ({m_c1, m_c0})
                2'b00:   sym = 10'h354;
                2'b01:   sym = 10'h0AB;
                2'b10:   sym = 10'h154;
                default: sym = 10'h2AB;
            endcase
            cnt = 0;
        end else begin
            n1 = 0;
            for (int i = 0; i < 8; i++) n1 += int'(d[i]);
            use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
            qm[0] = d[0];
            for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
            qm8 = use_xnor ? 0 : 1;
            n1q = 0;
            for (int i = 0; i < 8; i++) n1q += int'(qm[i]);
            n0q = 8 - n1q;
            if (cnt == 0 || n1q == n0q) begin
                sym = (qm8 == 1) ? {2'b01, qm} : {2'b10, ~qm};
                cnt += (qm8 == 1) ? (n1q - n0q) : (n0q - n1q);
            end else if ((cnt > 0 && n1q > n0q) || (cnt < 0 && n0q > n1q)) begin
                sym = {1'b1, qm8[0], ~qm};
                cnt += 2 * qm8 + n0q - n1q;
            end else begin
                sym = {1'b0, qm8[0], qm};
                cnt += -2 * (1 - qm8) + n1q - n0q;
            end
        end
    endtask

    // Apply inputs now (caller is at a negedge) and queue the expected symbol
    task automatic apply(input logic a_de, input logic a_c1, input logic a_c0, input logic [7:0] a_din,
                         input logic [9:0] e_sym, input int e_cnt);
        exp_t e;
        de = a_de; c1 = a_c1; c0 = a_c0; din = a_din;
        e.due = cur_edge + 2; e.sym = e_sym; e.cnt = e_cnt; e.is_data = a_de; e.d = a_din;
        exp_q.push_back(e);
    endtask

    task automatic dv(input logic a_de, input logic a_c1, input logic a_c0, input logic [7:0] a_din,
                      input logic [9:0] e_sym, input int e_cnt);
        @(negedge clk1x);
        apply(a_de, a_c1, a_c0, a_din, e_sym, e_cnt);
    endtask

    // Monitor: pop every expectation whose symbol is due on dout this cycle
    always @(negedge clk1x) begin
        exp_t e;
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].due <= cur_edge) begin
                e = exp_q.pop_front();
                check("latency", cur_edge, e.due);
                check("dout", {22'd0, dout}, {22'd0, e.sym});
`ifdef TMDS_DISP_MON_EN
                check("disp", disp, e.cnt);
                check("disp_bound", (disp <= 16 && disp >= -16) ? 1 : 0, 1);
`endif
                if (e.is_data) check("decode", {24'd0, decode(dout)}, {24'd0, e.d});
            end
        end
    end

    initial begin
        logic [9:0] sym;
        logic       r_de_v, r_c1_v, r_c0_v;
        logic [7:0] r_din_v;

        repeat (3) @(posedge clk1x);
        #1;
        check("reset_dout", {22'd0, dout}, 32'h354);
`ifdef TMDS_DISP_MON_EN
        check("reset_disp", disp, 0);
`endif
        @(negedge clk1x);
        rst_n = 1'b1;
        apply(1'b0, 1'b0, 1'b0, 8'h00, 10'h354, 0);
        dv(1'b0, 1'b0, 1'b1, 8'h00, 10'h0AB, 0);
        dv(1'b0, 1'b1, 1'b0, 8'h00, 10'h154, 0);
        dv(1'b0, 1'b1, 1'b1, 8'h00, 10'h2AB, 0);
        dv(1'b1, 1'b0, 1'b0, 8'h00, 10'h100, -8);
        dv(1'b1, 1'b0, 1'b0, 8'h00, 10'h3FF, 2);
        dv(1'b1, 1'b0, 1'b0, 8'h00, 10'h100, -6);
        dv(1'b0, 1'b0, 1'b0, 8'h00, 10'h354, 0);
        dv(1'b1, 1'b0, 1'b0, 8'h0F, 10'h105, -4);
        dv(1'b1, 1'b0, 1'b0, 8'hF0, 10'h0FA, -2);
        dv(1'b0, 1'b0, 1'b0, 8'h00, 10'h354, 0);
        dv(1'b1, 1'b0, 1'b0, 8'hF0, 10'h205, -4);
        dv(1'b1, 1'b1, 1'b1, 8'h00, 10'h3FF, 6);
        dv(1'b0, 1'b0, 1'b1, 8'hFF, 10'h0AB, 0);
        dv(1'b1, 1'b0, 1'b0, 8'hFF, 10'h200, -8);
        dv(1'b1, 1'b0, 1'b0, 8'h55, 10'h133, -8);
        dv(1'b1, 1'b0, 1'b0, 8'h00, 10'h3FF, 2);
        dv(1'b1, 1'b0, 1'b0, 8'hFF, 10'h200, -6);

        // Asynchronous reset in the middle of a data burst
        @(posedge clk1x);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_dout", {22'd0, dout}, 32'h354);
`ifdef TMDS_DISP_MON_EN
        check("midreset_disp", disp, 0);
`endif
        repeat (2) @(negedge clk1x);
        rst_n = 1'b1;
        apply(1'b1, 1'b0, 1'b0, 8'hFF, 10'h200, -8);
        mdl_cnt = -8;
        @(negedge clk1x);
        check("refill_dout", {22'd0, dout}, 32'h354);

        for (int n = 0; n < 2000; n++) begin
            r_de_v  = ($urandom_range(0, 3) != 0);
            r_c1_v  = $urandom_range(0, 1) == 1;
            r_c0_v  = $urandom_range(0, 1) == 1;
            r_din_v = 8'($urandom_range(0, 255));
            model(r_de_v, r_c1_v, r_c0_v, r_din_v, mdl_cnt, sym);
            apply(r_de_v, r_c1_v, r_c0_v, r_din_v, sym, mdl_cnt);
            @(negedge clk1x);
        end

        repeat (4) @(negedge clk1x);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
